// File: rtl/bp_ghr_ctrl.sv
// Gshare PHT controller: speculative global history, mispredict repair and a
// small FIFO that trains the PHT through its single write port.
module bp_ghr_ctrl #(
  parameter int d_width  = 8,
  parameter int HIST_W   = 8,
  parameter int UQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_fetch_valid,
  input  logic [31:0]        i_fetch_pc,
  input  logic               i_pht_predict,
  output logic [d_width-1:0] o_pht_addr,
  output logic               o_predict_taken,
  output logic [HIST_W-1:0]  o_predict_ghr,
  input  logic               i_resolve_valid,
  input  logic [d_width-1:0] i_resolve_idx,
  input  logic               i_resolve_taken,
  input  logic               i_resolve_mispredict,
  input  logic [HIST_W-1:0]  i_resolve_ghr,
  output logic               o_resolve_ready,
  input  logic               i_update_hold,
  output logic               o_pht_update,
  output logic [d_width-1:0] o_pht_addr_update,
  output logic               o_pht_actual_taken,
  output logic [15:0]        o_mispredict_cnt
);

  localparam int PTR_W = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(UQ_DEPTH + 1);

  logic [HIST_W-1:0]  ghr;
  logic [HIST_W-1:0]  ghr_next;
  logic [HIST_W-1:0]  ghr_repair;
  logic [HIST_W-1:0]  ghr_shift;
  logic [d_width-1:0] ghr_ext;
  logic               mispredict;

  logic [d_width-1:0] q_idx   [UQ_DEPTH];
  logic               q_taken [UQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [d_width-1:0] last_idx;
  logic               last_taken;

  logic unused_pc;
  assign unused_pc = ^{i_fetch_pc[31:d_width+2], i_fetch_pc[1:0]};

  assign mispredict = i_resolve_valid & i_resolve_mispredict;

  generate
    if (HIST_W == 1) begin : g_hist1
      logic unused_rghr;
      assign unused_rghr = i_resolve_ghr[0];
      assign ghr_repair  = i_resolve_taken;
      assign ghr_shift   = i_pht_predict;
    end else begin : g_histn
      assign ghr_repair = {i_resolve_ghr[HIST_W-2:0], i_resolve_taken};
      assign ghr_shift  = {ghr[HIST_W-2:0], i_pht_predict};
    end
  endgenerate

  // Repair wins over a same-cycle fetch shift: that fetch is on the wrong path.
  always_comb begin
    ghr_next = ghr;
    if (mispredict) begin
      ghr_next = ghr_repair;
    end else if (i_fetch_valid) begin
      ghr_next = ghr_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  always_comb begin
    ghr_ext              = '0;
    ghr_ext[HIST_W-1:0]  = ghr;
  end

  assign o_pht_addr      = i_fetch_pc[d_width+1:2] ^ ghr_ext;
  assign o_predict_taken = i_pht_predict;
  assign o_predict_ghr   = ghr;

  // Ready looks only at the registered count; a same-cycle pop gives no credit.
  assign o_resolve_ready = (count != CNT_W'(UQ_DEPTH));
  assign push            = i_resolve_valid & o_resolve_ready;
  assign o_pht_update    = (count != '0) & ~i_update_hold;
  assign pop             = o_pht_update;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < UQ_DEPTH; i++) begin
        q_idx[i]   <= '0;
        q_taken[i] <= 1'b0;
      end
      wr_ptr <= '0;
    end else if (push) begin
      q_idx[wr_ptr]   <= i_resolve_idx;
      q_taken[wr_ptr] <= i_resolve_taken;
      wr_ptr          <= wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      last_idx   <= '0;
      last_taken <= 1'b0;
    end else if (pop) begin
      rd_ptr     <= rd_ptr + PTR_W'(1);
      last_idx   <= q_idx[rd_ptr];
      last_taken <= q_taken[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // When empty the update port shows the most recently drained entry.
  always_comb begin
    o_pht_addr_update  = last_idx;
    o_pht_actual_taken = last_taken;
    if (count != '0) begin
      o_pht_addr_update  = q_idx[rd_ptr];
      o_pht_actual_taken = q_taken[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mispredict_cnt <= '0;
    end else if (mispredict && (o_mispredict_cnt != 16'hFFFF)) begin
      o_mispredict_cnt <= o_mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bp_ghr_ctrl.sv
// Directed bench for bp_ghr_ctrl; PHT updates are checked by a scoreboard
// monitor, combinational/status outputs by direct comparisons.
module tb_bp_ghr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_pc;
  logic        i_pht_predict;
  logic [7:0]  o_pht_addr;
  logic        o_predict_taken;
  logic [7:0]  o_predict_ghr;
  logic        i_resolve_valid;
  logic [7:0]  i_resolve_idx;
  logic        i_resolve_taken;
  logic        i_resolve_mispredict;
  logic [7:0]  i_resolve_ghr;
  logic        o_resolve_ready;
  logic        i_update_hold;
  logic        o_pht_update;
  logic [7:0]  o_pht_addr_update;
  logic        o_pht_actual_taken;
  logic [15:0] o_mispredict_cnt;

  typedef struct packed {
    logic [7:0] idx;
    logic       taken;
  } upd_t;

  upd_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  bp_ghr_ctrl #(.d_width(8), .HIST_W(8), .UQ_DEPTH(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_fetch_valid       (i_fetch_valid),
    .i_fetch_pc          (i_fetch_pc),
    .i_pht_predict       (i_pht_predict),
    .o_pht_addr          (o_pht_addr),
    .o_predict_taken     (o_predict_taken),
    .o_predict_ghr       (o_predict_ghr),
    .i_resolve_valid     (i_resolve_valid),
    .i_resolve_idx       (i_resolve_idx),
    .i_resolve_taken     (i_resolve_taken),
    .i_resolve_mispredict(i_resolve_mispredict),
    .i_resolve_ghr       (i_resolve_ghr),
    .o_resolve_ready     (o_resolve_ready),
    .i_update_hold       (i_update_hold),
    .o_pht_update        (o_pht_update),
    .o_pht_addr_update   (o_pht_addr_update),
    .o_pht_actual_taken  (o_pht_actual_taken),
    .o_mispredict_cnt    (o_mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every update strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && o_pht_update) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_update actual_addr=0x%0h required=none", o_pht_addr_update);
      end else begin
        upd_t e;
        e = exp_q.pop_front();
        if (o_pht_addr_update !== e.idx || o_pht_actual_taken !== e.taken) begin
          failures++;
          $display("FAIL update_order actual=0x%0h/%0b required=0x%0h/%0b",
                   o_pht_addr_update, o_pht_actual_taken, e.idx, e.taken);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [7:0] idx, input logic taken, input logic misp,
                         input logic [7:0] rghr, input logic expect_push);
    i_resolve_valid      = 1'b1;
    i_resolve_idx        = idx;
    i_resolve_taken      = taken;
    i_resolve_mispredict = misp;
    i_resolve_ghr        = rghr;
    if (expect_push) exp_q.push_back('{idx: idx, taken: taken});
  endtask

  task automatic no_resolve();
    i_resolve_valid      = 1'b0;
    i_resolve_mispredict = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_fetch_valid = 1'b0;
    i_fetch_pc = 32'h0000_0040;
    i_pht_predict = 1'b0;
    i_resolve_valid = 1'b0;
    i_resolve_idx = '0;
    i_resolve_taken = 1'b0;
    i_resolve_mispredict = 1'b0;
    i_resolve_ghr = '0;
    i_update_hold = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_update", o_pht_update, 0);
    chk("rst_addr_update", o_pht_addr_update, 0);
    chk("rst_ready", o_resolve_ready, 1);
    chk("rst_cnt", o_mispredict_cnt, 0);
    chk("rst_pht_addr", o_pht_addr, 8'h10);
    chk("rst_ghr", o_predict_ghr, 0);

    // 1: three predicted-taken fetches shift history
    next_cycle();
    rst_n = 1'b1;
    i_fetch_valid = 1'b1;
    i_pht_predict = 1'b1;
    @(negedge clk); chk("idx_0", o_pht_addr, 8'h10);
    chk("predict_taken", o_predict_taken, 1);
    next_cycle();
    @(negedge clk); chk("idx_1", o_pht_addr, 8'h11);
    next_cycle();
    @(negedge clk); chk("idx_2", o_pht_addr, 8'h13);
    next_cycle();
    i_fetch_valid = 1'b0;
    @(negedge clk); chk("ghr_after_fetch", o_predict_ghr, 8'h07);

    // 2: mispredict repair beats the same-cycle fetch shift
    next_cycle();
    i_fetch_valid = 1'b1;
    resolve(8'h55, 1'b0, 1'b1, 8'h03, 1'b1);
    @(negedge clk); chk("ghr_snapshot", o_predict_ghr, 8'h07);
    chk("no_update_same_cycle", o_pht_update, 0);
    next_cycle();
    i_fetch_valid = 1'b0;
    no_resolve();
    @(negedge clk); chk("ghr_repair", o_predict_ghr, 8'h06);
    chk("misp_cnt_1", o_mispredict_cnt, 1);
    chk("repair_entry_drains", o_pht_update, 1);

    // 3: fill under hold, drop the fifth, then drain in order
    next_cycle();
    i_update_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resolve(8'(i + 1), (i % 2 == 0), 1'b0, 8'h00, 1'b1);
      @(negedge clk); chk("ready_before_full", o_resolve_ready, 1);
      chk("held_no_update", o_pht_update, 0);
      next_cycle();
    end
    resolve(8'h05, 1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk); chk("ready_full", o_resolve_ready, 0);
    next_cycle();
    no_resolve();
    i_update_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("drain_consecutive", o_pht_update, 1);
      next_cycle();
    end
    @(negedge clk); chk("drain_done", o_pht_update, 0);
    chk("ready_after_drain", o_resolve_ready, 1);
    chk("hold_last_addr", o_pht_addr_update, 8'h04);
    chk("ghr_held", o_predict_ghr, 8'h06);

    // 4: single resolve appears exactly one cycle later, for one cycle
    next_cycle();
    resolve(8'hAB, 1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clk); chk("lat_cycle0", o_pht_update, 0);
    next_cycle();
    no_resolve();
    @(negedge clk); chk("lat_cycle1", o_pht_update, 1);
    chk("lat_addr", o_pht_addr_update, 8'hAB);
    chk("lat_taken", o_pht_actual_taken, 1);
    next_cycle();
    @(negedge clk); chk("lat_cycle2", o_pht_update, 0);

    // 5: steady push+pop at count 2 across pointer wrap
    next_cycle();
    i_update_hold = 1'b1;
    resolve(8'h20, 1'b0, 1'b0, 8'h00, 1'b1);
    next_cycle();
    resolve(8'h21, 1'b1, 1'b0, 8'h00, 1'b1);
    next_cycle();
    i_update_hold = 1'b0;
    for (int j = 0; j < 6; j++) begin
      resolve(8'(8'h22 + j), j[0], 1'b0, 8'h00, 1'b1);
      @(negedge clk); chk("pp_ready", o_resolve_ready, 1);
      chk("pp_update", o_pht_update, 1);
      next_cycle();
    end
    no_resolve();
    @(negedge clk); chk("pp_tail0", o_pht_update, 1);
    next_cycle();
    @(negedge clk); chk("pp_tail1", o_pht_update, 1);
    next_cycle();
    @(negedge clk); chk("pp_empty", o_pht_update, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    // 6: asynchronous reset mid-drain discards queued entries
    next_cycle();
    i_update_hold = 1'b1;
    resolve(8'h30, 1'b1, 1'b0, 8'h00, 1'b1);
    next_cycle();
    resolve(8'h31, 1'b0, 1'b0, 8'h00, 1'b1);
    next_cycle();
    resolve(8'h32, 1'b1, 1'b0, 8'h00, 1'b1);
    next_cycle();
    no_resolve();
    i_update_hold = 1'b0;
    @(negedge clk); chk("pre_reset_update", o_pht_update, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_update", o_pht_update, 0);
    chk("async_ghr", o_predict_ghr, 0);
    chk("async_ready", o_resolve_ready, 1);
    chk("async_cnt", o_mispredict_cnt, 0);
    chk("async_addr_update", o_pht_addr_update, 0);
    exp_q.delete();
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("no_stale_update", o_pht_update, 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_ghr_ctrl.md
Name: bp_ghr_ctrl

Overview:
Gshare-style controller sequencing the 2-bit-counter pattern history table (PHT).
- Keeps the speculative global history register (GHR) and forms the PHT lookup index from fetch PC xor GHR.
- Repairs the GHR on a branch mispredict.
- Buffers resolved-branch outcomes in a small queue and drains them one per cycle onto the PHT's single update port.

Parameters:
d_width, 8, PHT index width; must match the PHT.
HIST_W, 8, GHR width; 1 <= HIST_W <= d_width.
UQ_DEPTH, 4, update-queue entries; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
i_fetch_valid  in  1  fetch slot holds a conditional branch needing a prediction.
i_fetch_pc  in  32  PC of that branch.
i_pht_predict  in  1  PHT prediction for o_pht_addr; PHT read is combinational.
o_pht_addr  out  d_width  PHT lookup index.
o_predict_taken  out  1  prediction returned to fetch.
o_predict_ghr  out  HIST_W  GHR snapshot carried down the pipe with the branch.
i_resolve_valid  in  1  branch resolved in EX.
i_resolve_idx  in  d_width  PHT index the branch used at fetch.
i_resolve_taken  in  1  actual outcome.
i_resolve_mispredict  in  1  prediction was wrong; qualified by i_resolve_valid.
i_resolve_ghr  in  HIST_W  GHR snapshot carried with the branch.
o_resolve_ready  out  1  queue can accept a resolve.
i_update_hold  in  1  PHT must not be written this cycle.
o_pht_update  out  1  PHT update strobe.
o_pht_addr_update  out  d_width  PHT update index.
o_pht_actual_taken  out  1  PHT update outcome.
o_mispredict_cnt  out  16  saturating mispredict counter.

Behaviour:
- Reset: spec GHR=0; queue empty (count=0, pointers=0); o_mispredict_cnt=0. Outputs at reset:
  - o_pht_update=0, o_pht_addr_update=0, o_pht_actual_taken=0.
  - o_resolve_ready=1.
  - o_pht_addr = i_fetch_pc[d_width+1:2] (GHR=0).
  - Reset is asynchronous and may assert mid-operation; queued updates are discarded and all state returns to reset values.
- Index, combinational: o_pht_addr = i_fetch_pc[d_width+1:2] XOR zero-extend(GHR) to d_width.
  - o_predict_taken = i_pht_predict.
  - o_predict_ghr = current GHR, before any shift this cycle.
  - Prediction latency: 0 cycles.
- GHR update at clock edge, in priority order:
  1. i_resolve_valid & i_resolve_mispredict: GHR <= {i_resolve_ghr[HIST_W-2:0], i_resolve_taken}. For HIST_W=1: GHR <= i_resolve_taken. A same-cycle fetch shift is dropped; that fetch is on the wrong path.
  2. Otherwise, if i_fetch_valid: GHR <= {GHR[HIST_W-2:0], i_pht_predict}.
  3. Otherwise GHR holds.
- Mispredict repair applies even when o_resolve_ready=0.
- Update queue (FIFO):
  - Push on i_resolve_valid & o_resolve_ready, storing {i_resolve_idx, i_resolve_taken}.
  - o_resolve_ready = (count != UQ_DEPTH), computed from registered count only (no same-cycle pop credit).
  - Resolve while not ready: the entry is dropped (lossy training permitted); the GHR repair still occurs.
- Drain:
  - o_pht_update = (count != 0) & ~i_update_hold, combinational.
  - o_pht_addr_update / o_pht_actual_taken = head entry. When empty, they hold their last value, or 0 after reset.
  - Pop when o_pht_update=1.
- Resolve-to-update latency: a push in cycle N is first visible on o_pht_update in cycle N+1; the PHT commits at the end of N+1.
- Simultaneous push and pop: count unchanged; pointers advance modulo UQ_DEPTH. Order is strictly FIFO.
- Counter: o_mispredict_cnt increments on i_resolve_valid & i_resolve_mispredict. It saturates at 16'hFFFF, with no wrap.
- Inputs are assumed stable around the clock edge; there is no input registering.

Test Plan:
1. Reset, then i_fetch_pc=0x0000_0040, i_pht_predict=1, i_fetch_valid=1 for 3 cycles:
   - o_pht_addr sequence = 0x10, 0x11, 0x13.
   - GHR = 0x07 afterwards.
2. GHR=0x07, resolve with mispredict=1, taken=0, ghr=0x03, while i_fetch_valid=1, predict=1:
   - next GHR = 0x06, not 0x0F.
   - o_mispredict_cnt = 1.
3. i_update_hold=1; push 4 resolves with idx 0x01..0x04 and taken 1,0,1,0:
   - o_resolve_ready falls after the 4th push.
   - A 5th resolve (idx 0x05) is dropped.
   - Release hold: updates 0x01..0x04 appear on 4 consecutive cycles in order.
4. Single resolve idx=0xAB, taken=1, queue empty, hold=0:
   - o_pht_update=1 with addr 0xAB exactly one cycle later, for one cycle.
5. Queue at count 2 with simultaneous push and pop for 6 cycles:
   - count stays 2.
   - Pointer wrap-around preserves FIFO order.
6. Assert rst_n low mid-drain with 3 entries queued:
   - o_pht_update=0 immediately, GHR=0, o_resolve_ready=1.
   - No stale entry is emitted after reset release.
